// File: rtl/i2c_slave_pkg.sv
// Shared types and defaults for the I2C slave controller.
package i2c_slave_pkg;

  localparam int         BYTE_W             = 8;
  localparam logic [6:0] DEF_SLAVE_ADDR     = 7'h20;
  localparam int         DEF_NUM_REGS       = 16;
  localparam int         DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_DATA   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } i2c_state_t;

endpackage

// File: rtl/i2c_bus_timer.sv
// Bus-idle watchdog: down-counter reloaded on clr_i, expire_o pulses at terminal count.
module i2c_bus_timer
  import i2c_slave_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clr_i || (cnt_q == '0)) begin
      cnt_d = LOAD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = !clr_i && (cnt_q == '0);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Control FSM sequencing the I2C slave datapath from synchronized SCL strobes and START/STOP flags.
// Optional bus-idle timeout is built in when I2C_SLAVE_TIMEOUT_EN is defined.
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         NUM_REGS   = DEF_NUM_REGS
`ifdef I2C_SLAVE_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              SCL_posedge_i,
  input  logic              SCL_negedge_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              bit_done_i,
  input  logic [BYTE_W-1:0] data_in_i,
  input  logic              ack_in_i,
  output logic              clear_start_o,
  output logic              clear_stop_o,
  output logic              cnt_clear_o,
  output logic              shift_en_o,
  output logic              sel_load_o,
  output logic              sel_inc_o,
  output logic              we_o,
  output logic              send_ack_o,
  output logic              out_en_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam logic [BYTE_W:0] NUM_REGS_W = (BYTE_W + 1)'(NUM_REGS);

  i2c_state_t state_q, state_d;
  logic       rw_q, rw_d;
  logic       clear_start_q, clear_start_d;
  logic       clear_stop_q, clear_stop_d;
  logic       cnt_clear_q, cnt_clear_d;
  logic       timeout_q, timeout_d;
  logic       expire;
  logic       addr_match;
  logic       reg_ok;

  assign addr_match = (data_in_i[7:1] == SLAVE_ADDR);
  assign reg_ok     = ({1'b0, data_in_i} < NUM_REGS_W);

`ifdef I2C_SLAVE_TIMEOUT_EN
  logic timer_clr;
  assign timer_clr = SCL_posedge_i | SCL_negedge_i | (state_q == IDLE);

  i2c_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (timer_clr),
    .expire_o(expire)
  );
`else
  logic unused_scl_posedge;
  assign unused_scl_posedge = SCL_posedge_i;
  assign expire             = 1'b0;
`endif

  // Flags stay set until our registered clear lands, so ignore them while that clear is in flight.
  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    clear_start_d = 1'b0;
    clear_stop_d  = 1'b0;
    cnt_clear_d   = 1'b0;
    timeout_d     = 1'b0;
    if (stop_i && !clear_stop_q) begin
      clear_stop_d  = 1'b1;
      clear_start_d = start_i && !clear_start_q;
      state_d       = IDLE;
    end else if (start_i && !clear_start_q) begin
      clear_start_d = 1'b1;
      cnt_clear_d   = 1'b1;
      state_d       = ADDR;
    end else if (expire) begin
      timeout_d   = 1'b1;
      cnt_clear_d = 1'b1;
      state_d     = IDLE;
    end else if (SCL_negedge_i) begin
      unique case (state_q)
        ADDR: begin
          if (bit_done_i) begin
            rw_d    = data_in_i[0];
            state_d = addr_match ? ADDR_ACK : WAIT_STOP;
          end
        end
        ADDR_ACK: begin
          cnt_clear_d = 1'b1;
          state_d     = rw_q ? RD_DATA : REG;
        end
        REG: begin
          if (bit_done_i) state_d = reg_ok ? REG_ACK : WAIT_STOP;
        end
        REG_ACK, WR_ACK: begin
          cnt_clear_d = 1'b1;
          state_d     = WR_DATA;
        end
        WR_DATA: begin
          if (bit_done_i) state_d = WR_ACK;
        end
        RD_DATA: begin
          if (bit_done_i) state_d = RD_ACK;
        end
        RD_ACK: begin
          if (ack_in_i) begin
            cnt_clear_d = 1'b1;
            state_d     = RD_DATA;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rw_q          <= 1'b0;
      clear_start_q <= 1'b0;
      clear_stop_q  <= 1'b0;
      cnt_clear_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      clear_start_q <= clear_start_d;
      clear_stop_q  <= clear_stop_d;
      cnt_clear_q   <= cnt_clear_d;
      timeout_q     <= timeout_d;
    end
  end

  // Out-of-range pointer bytes are NACKed and must not disturb the pointer.
  assign shift_en_o    = (state_q == ADDR) || (state_q == REG) || (state_q == WR_DATA);
  assign sel_load_o    = (state_q == REG) && bit_done_i && reg_ok;
  assign sel_inc_o     = (state_q == WR_ACK) || ((state_q == RD_ACK) && ack_in_i);
  assign we_o          = (state_q == WR_DATA) && bit_done_i;
  assign send_ack_o    = (state_q == ADDR_ACK) || (state_q == REG_ACK) || (state_q == WR_ACK);
  assign out_en_o      = (state_q == RD_DATA);
  assign busy_o        = (state_q != IDLE);
  assign clear_start_o = clear_start_q;
  assign clear_stop_o  = clear_stop_q;
  assign cnt_clear_o   = cnt_clear_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: behavioural datapath around the FSM, scoreboard of ACK bits and read bytes.
module tb_i2c_slave_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       scl_pos, scl_neg;
  logic       start_f, stop_f;
  logic       bit_done;
  logic [7:0] data_in;
  logic       ack_in;
  logic       clear_start, clear_stop, cnt_clear, shift_en, sel_load, sel_inc;
  logic       we, send_ack, out_en, busy, timeout;

  logic       req_start, req_stop, sda_m;
  logic [7:0] dp_sh;
  logic [3:0] dp_cnt;
  logic [3:0] dp_ptr;
  logic       dp_ack;
  logic [7:0] dp_reg [16];
  int         we_cnt, load_cnt, to_cnt, wide_cnt;
  logic [3:0] pulse_prev;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  i2c_slave_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .SCL_posedge_i(scl_pos),
    .SCL_negedge_i(scl_neg),
    .start_i      (start_f),
    .stop_i       (stop_f),
    .bit_done_i   (bit_done),
    .data_in_i    (data_in),
    .ack_in_i     (ack_in),
    .clear_start_o(clear_start),
    .clear_stop_o (clear_stop),
    .cnt_clear_o  (cnt_clear),
    .shift_en_o   (shift_en),
    .sel_load_o   (sel_load),
    .sel_inc_o    (sel_inc),
    .we_o         (we),
    .send_ack_o   (send_ack),
    .out_en_o     (out_en),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  assign bit_done = (dp_cnt == 4'd8);
  assign data_in  = dp_sh;
  assign ack_in   = dp_ack;

  // Datapath model: flags, shifter, bit counter, pointer, register file.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      start_f    <= 1'b0;
      stop_f     <= 1'b0;
      dp_sh      <= 8'h00;
      dp_cnt     <= 4'd0;
      dp_ptr     <= 4'd0;
      dp_ack     <= 1'b0;
      we_cnt     <= 0;
      load_cnt   <= 0;
      to_cnt     <= 0;
      wide_cnt   <= 0;
      pulse_prev <= 4'b0;
      for (int i = 0; i < 16; i++) dp_reg[i] <= 8'(8'h10 + i);
    end else begin
      if (req_start) start_f <= 1'b1;
      else if (clear_start) start_f <= 1'b0;
      if (req_stop) stop_f <= 1'b1;
      else if (clear_stop) stop_f <= 1'b0;
      if (cnt_clear) dp_cnt <= 4'd0;
      else if (scl_pos && (shift_en || out_en)) dp_cnt <= dp_cnt + 4'd1;
      if (scl_pos && shift_en) dp_sh <= {dp_sh[6:0], sda_m};
      if (scl_pos) dp_ack <= !sda_m;
      if (scl_neg) begin
        if (sel_load) begin
          dp_ptr   <= dp_sh[3:0];
          load_cnt <= load_cnt + 1;
        end
        if (we) begin
          dp_reg[dp_ptr] <= dp_sh;
          we_cnt         <= we_cnt + 1;
        end
        if (sel_inc) dp_ptr <= dp_ptr + 4'd1;
      end
      if (timeout) to_cnt <= to_cnt + 1;
      if (({clear_start, clear_stop, cnt_clear, timeout} & pulse_prev) != 4'b0) wide_cnt <= wide_cnt + 1;
      pulse_prev <= {clear_start, clear_stop, cnt_clear, timeout};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic scl_rise();
    scl_pos = 1'b1;
    @(negedge clock);
    scl_pos = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic scl_fall();
    scl_neg = 1'b1;
    @(negedge clock);
    scl_neg = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    scl_rise();
    req_start = 1'b1;
    @(negedge clock);
    req_start = 1'b0;
    repeat (3) @(negedge clock);
    scl_fall();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    scl_rise();
    req_stop = 1'b1;
    @(negedge clock);
    req_stop = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic       got;
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      scl_rise();
      scl_fall();
    end
    sda_m = 1'b1;
    exp_q.push_back({7'b0, exp_ack});
    got = send_ack;
    scl_rise();
    scl_fall();
    exp = exp_q.pop_front();
    chk(tag, {31'b0, got}, {24'b0, exp});
  endtask

  task automatic read_byte(input logic [7:0] exp_byte, input logic master_ack, input string tag);
    logic [7:0] got;
    logic       b;
    logic [7:0] exp;
    exp_q.push_back(exp_byte);
    got   = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b   = out_en ? dp_reg[dp_ptr][3'(7 - dp_cnt)] : 1'b1;
      got = {got[6:0], b};
      scl_rise();
      scl_fall();
    end
    chk({tag, "_oe_in_ack"}, {31'b0, out_en}, 32'd0);
    sda_m = !master_ack;
    scl_rise();
    scl_fall();
    sda_m = 1'b1;
    exp = exp_q.pop_front();
    chk(tag, {24'b0, got}, {24'b0, exp});
  endtask

  initial begin
    int we_snap, load_snap;
    reset     = 1'b1;
    scl_pos   = 1'b0;
    scl_neg   = 1'b0;
    req_start = 1'b0;
    req_stop  = 1'b0;
    sda_m     = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {21'b0, clear_start, clear_stop, cnt_clear, shift_en, sel_load,
                          sel_inc, we, send_ack, out_en, busy, timeout}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // write 0xA5 to reg 3
    i2c_start();
    chk("addr_busy", {31'b0, busy}, 32'd1);
    chk("addr_shift_en", {31'b0, shift_en}, 32'd1);
    write_byte(8'h40, 1'b1, "wr_addr_ack");
    write_byte(8'h03, 1'b1, "wr_reg_ack");
    chk("wr_ptr_load", {28'b0, dp_ptr}, 32'd3);
    write_byte(8'hA5, 1'b1, "wr_data_ack");
    i2c_stop();
    chk("wr_reg3", {24'b0, dp_reg[3]}, 32'hA5);
    chk("wr_ptr_inc", {28'b0, dp_ptr}, 32'd4);
    chk("wr_idle", {31'b0, busy}, 32'd0);

    // burst read from reg 1 with repeated START
    i2c_start();
    write_byte(8'h40, 1'b1, "rd_addr_w_ack");
    write_byte(8'h01, 1'b1, "rd_reg_ack");
    i2c_start();
    write_byte(8'h41, 1'b1, "rd_addr_r_ack");
    chk("rd_out_en", {31'b0, out_en}, 32'd1);
    read_byte(8'h11, 1'b1, "rd_byte0");
    read_byte(8'h12, 1'b0, "rd_byte1");
    chk("rd_wait_stop_busy", {31'b0, busy}, 32'd1);
    chk("rd_wait_stop_oe", {31'b0, out_en}, 32'd0);
    i2c_stop();
    chk("rd_idle", {31'b0, busy}, 32'd0);
    chk("rd_ptr", {28'b0, dp_ptr}, 32'd2);

    // wrong address
    we_snap   = we_cnt;
    load_snap = load_cnt;
    i2c_start();
    write_byte(8'h42, 1'b0, "bad_addr_nack");
    chk("bad_addr_busy", {31'b0, busy}, 32'd1);
    write_byte(8'h03, 1'b0, "bad_addr_byte1");
    write_byte(8'h77, 1'b0, "bad_addr_byte2");
    chk("bad_addr_no_load", load_cnt, load_snap);
    chk("bad_addr_no_we", we_cnt, we_snap);
    i2c_stop();
    chk("bad_addr_idle", {31'b0, busy}, 32'd0);

    // out-of-range pointer
    i2c_start();
    write_byte(8'h40, 1'b1, "oor_addr_ack");
    write_byte(8'h15, 1'b0, "oor_reg_nack");
    chk("oor_ptr", {28'b0, dp_ptr}, 32'd2);
    write_byte(8'h99, 1'b0, "oor_data_nack");
    chk("oor_no_we", we_cnt, we_snap);
    chk("oor_reg2", {24'b0, dp_reg[2]}, 32'h12);
    i2c_stop();

    // STOP after 4 data bits
    i2c_start();
    write_byte(8'h40, 1'b1, "part_addr_ack");
    write_byte(8'h05, 1'b1, "part_reg_ack");
    for (int i = 0; i < 4; i++) begin
      sda_m = 1'b1;
      scl_rise();
      scl_fall();
    end
    i2c_stop();
    chk("part_idle", {31'b0, busy}, 32'd0);
    chk("part_no_we", we_cnt, we_snap);
    chk("part_reg5", {24'b0, dp_reg[5]}, 32'h15);

    // bus stall in RD_DATA
    i2c_start();
    write_byte(8'h41, 1'b1, "to_addr_ack");
    for (int i = 0; i < 3; i++) begin
      scl_rise();
      scl_fall();
    end
    chk("to_pre_oe", {31'b0, out_en}, 32'd1);
    repeat (i2c_slave_pkg::DEF_TIMEOUT_CYCLES + 20) @(negedge clock);
`ifdef I2C_SLAVE_TIMEOUT_EN
    chk("to_pulses", to_cnt, 32'd1);
    chk("to_oe", {31'b0, out_en}, 32'd0);
    chk("to_busy", {31'b0, busy}, 32'd0);
`else
    chk("to_pulses", to_cnt, 32'd0);
    chk("to_oe", {31'b0, out_en}, 32'd1);
    chk("to_busy", {31'b0, busy}, 32'd1);
`endif
    i2c_stop();
    chk("to_end_idle", {31'b0, busy}, 32'd0);
    chk("pulse_width", wide_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
